// File: rtl/pipelined_write_rx_pkg.sv
// Shared types and default sizing for the pipelined write receiver.
package pipelined_write_rx_pkg;

    // Default data-cycle width and maximum beats per write
    localparam int PWR_DEF_WR_WIDTH      = 8;
    localparam int PWR_DEF_MAX_WR_CYCLES = 4;

    // How completion is reported for a write
    typedef enum logic [1:0] {
        WT_STD          = 2'd0,
        WT_MULTI_WDONE  = 2'd1,
        WT_SINGLE_WDONE = 2'd2
    } write_type_e;

    // Qualifier carried with every data cycle
    typedef enum logic [1:0] {
        CT_IDLE  = 2'd0,
        CT_VALID = 2'd1,
        CT_DONE  = 2'd2
    } cycle_type_e;

endpackage

// File: rtl/pipelined_write_rx.sv
// Pipelined write receiver: a command cycle announces a write of up to
// MAX_WR_CYCLES data beats; the beats are assembled into one wide word
// which is then held on out_* until the consumer accepts it.
// Optional feature: define PIPELINED_WRITE_RX_ERR_CNT_EN to build a
// saturating 16-bit protocol-error counter on err_cnt (tied to 0 otherwise).
module pipelined_write_rx
    import pipelined_write_rx_pkg::*;
#(
    parameter int WR_WIDTH      = PWR_DEF_WR_WIDTH,
    parameter int MAX_WR_CYCLES = PWR_DEF_MAX_WR_CYCLES,
    parameter int CNT_W         = $clog2(MAX_WR_CYCLES)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_cmd_val,
    input  logic [CNT_W-1:0]                  in_num_cycles,
    input  logic [1:0]                        in_write_type,
    input  logic [1:0]                        in_cycle_type,
    input  logic [WR_WIDTH-1:0]               in_dat,
    output logic                              in_rdy,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [MAX_WR_CYCLES*WR_WIDTH-1:0] out_dat,
    output logic [CNT_W:0]                    out_num_beats,
    output logic [1:0]                        out_write_type,
    output logic                              wdone,
    output logic                              err,
    output logic [15:0]                       err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int             BUF_W   = MAX_WR_CYCLES * WR_WIDTH;
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_WR_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W:0]     need_q, need_d;     // beats expected for this write
    logic [CNT_W:0]     cnt_q, cnt_d;       // beats received so far (also slot index)
    logic [1:0]         wtype_q, wtype_d;
    logic [BUF_W-1:0]   buf_q, buf_d;       // assembly buffer, doubles as out_dat
    logic               err_q, err_d;
    logic               mwd_q, mwd_d;       // per-beat wdone, one cycle after the beat
    logic               start;              // a command is being accepted this cycle
    logic               beat;
    logic               is_done;

    assign beat    = (in_cycle_type == CT_VALID) || (in_cycle_type == CT_DONE);
    assign is_done = (in_cycle_type == CT_DONE);

    // Next-state, handshake and buffer update logic
    always_comb begin
        state_d = state_q;
        need_d  = need_q;
        cnt_d   = cnt_q;
        wtype_d = wtype_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        mwd_d   = 1'b0;
        start   = 1'b0;
        in_rdy  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_rdy = 1'b1;
                if (in_cmd_val) begin
                    start = 1'b1;
                end
            end
            ST_DATA: begin
                in_rdy = 1'b1;
                if (in_cmd_val) begin
                    // A new command mid-write aborts the partial write
                    err_d = 1'b1;
                    start = 1'b1;
                end else if (beat) begin
                    buf_d[int'(cnt_q[CNT_W-1:0]) * WR_WIDTH +: WR_WIDTH] = in_dat;
                    cnt_d = cnt_q + 1'b1;
                    mwd_d = (wtype_q == WT_MULTI_WDONE);
                    // DONE before the count is reached, or the last counted
                    // beat not marked DONE, are both protocol errors
                    if (is_done != (cnt_d == need_q)) begin
                        err_d = 1'b1;
                    end
                    if (is_done || (cnt_d == need_q)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_rdy) begin
                    in_rdy = 1'b1;
                    if (in_cmd_val) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d = ST_DATA;
            need_d  = (in_num_cycles == '0) ? MAX_CNT : {1'b0, in_num_cycles};
            cnt_d   = '0;
            wtype_d = in_write_type;
            buf_d   = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            need_q  <= '0;
            cnt_q   <= '0;
            wtype_q <= WT_STD;
            buf_q   <= '0;
            err_q   <= 1'b0;
            mwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            need_q  <= need_d;
            cnt_q   <= cnt_d;
            wtype_q <= wtype_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            mwd_q   <= mwd_d;
        end
    end

    assign out_vld        = (state_q == ST_HOLD);
    assign out_dat        = buf_q;
    assign out_num_beats  = cnt_q;
    assign out_write_type = wtype_q;
    assign err            = err_q;
    assign wdone          = mwd_q ||
                            (out_vld && out_rdy && (wtype_q == WT_SINGLE_WDONE));

`ifdef PIPELINED_WRITE_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of error pulses, updated alongside err
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
